// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, reads instruction memory over req/ack and
// registers one instruction (plus R-type flag) per cycle for decode.
module instruction_fetch #(
    parameter int                INST_LEN = 32,
    parameter int                PC_LEN   = 32,
    parameter logic [PC_LEN-1:0] RESET_PC = '0
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst,
    output logic                o_imem_req,
    output logic [PC_LEN-1:0]   o_imem_addr,
    input  logic                i_imem_ack,
    input  logic [INST_LEN-1:0] i_imem_rdata,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [PC_LEN-1:0]   i_redirect_pc,
    output logic                o_valid,
    output logic [INST_LEN-1:0] o_instruction,
    output logic                o_R_type,
    output logic [PC_LEN-1:0]   o_pc,
    output logic [1:0]          o_state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e              state_q;
    logic [PC_LEN-1:0]   pc_q;
    logic [PC_LEN-1:0]   stale_addr_q;
    logic [PC_LEN-1:0]   out_pc_q;
    logic [INST_LEN-1:0] instr_q;
    logic                valid_q;
    logic                rtype_q;

    logic [PC_LEN-1:0]   pc_seq_d;
    logic [PC_LEN-1:0]   pc_redir_d;
    logic                imem_req;
    logic                ack_fire;

    // Memory handshake: a request completes in the cycle where req && ack are
    // both high; until then req and addr are held. Req only drops when a live
    // output is stalled, which cannot coincide with an outstanding request
    // because an unstalled live output is always consumed first.
    always_comb begin
        imem_req = 1'b0;
        case (state_q)
            ST_FETCH: imem_req = !(valid_q && i_stall);
            ST_FLUSH: imem_req = 1'b1;
            default:  imem_req = 1'b0;
        endcase
    end

    assign ack_fire   = imem_req && i_imem_ack;
    assign pc_seq_d   = pc_q + PC_LEN'(4);
    assign pc_redir_d = i_redirect_pc & ~PC_LEN'(3);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            stale_addr_q <= '0;
            out_pc_q     <= '0;
            instr_q      <= '0;
            valid_q      <= 1'b0;
            rtype_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (i_redirect) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_redir_d;
                        if (imem_req && !i_imem_ack) begin
                            state_q      <= ST_FLUSH;
                            stale_addr_q <= pc_q;
                        end
                    end else if (ack_fire) begin
                        instr_q  <= i_imem_rdata;
                        rtype_q  <= (i_imem_rdata[INST_LEN-1 -: 6] == 6'b000000);
                        out_pc_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_seq_d;
                    end else if (valid_q && !i_stall) begin
                        valid_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // The stale word is never loaded; only the PC can move here.
                    valid_q <= 1'b0;
                    if (i_redirect) begin
                        pc_q <= pc_redir_d;
                    end
                    if (i_imem_ack) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_imem_req    = imem_req;
    assign o_imem_addr   = (state_q == ST_FLUSH) ? stale_addr_q : pc_q;
    assign o_valid       = valid_q;
    assign o_instruction = instr_q;
    assign o_R_type      = rtype_q;
    assign o_pc          = out_pc_q;
    assign o_state_dbg   = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random stall/redirect/
// memory-latency traffic checked against a transaction-level fetch model.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic        o_R_type;
    logic [31:0] o_pc;
    logic [1:0]  o_state_dbg;

    instruction_fetch #(
        .INST_LEN (32),
        .PC_LEN   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst     (rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_R_type      (o_R_type),
        .o_pc          (o_pc),
        .o_state_dbg   (o_state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // stimulus controls
    logic        stall_s    = 1'b0;
    logic        redir_s    = 1'b0;
    logic [31:0] redir_pc_s = '0;
    int          mem_delay  = 0;
    int          mem_cnt    = 0;
    logic        ovr_en     = 1'b0;
    logic [31:0] ovr_val    = '0;
    logic        last_req   = 1'b0;

    // reference model: what decode should see, and which address is wanted next
    logic        m_live;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_rtype;
    logic [31:0] m_fetch_pc;
    logic        m_stale;
    logic [31:0] m_stale_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ovr_en ? ovr_val : a + 32'h0000_A000;
    endfunction

    task automatic model_reset();
        m_live       = 1'b0;
        m_valid      = 1'b0;
        m_instr      = '0;
        m_pc         = '0;
        m_rtype      = 1'b0;
        m_fetch_pc   = RESET_PC;
        m_stale      = 1'b0;
        m_stale_addr = '0;
        mem_cnt      = 0;
    endtask

    // ---------------- driver: one clock cycle, starting after a negedge ----------------
    task automatic step();
        logic        req_seen;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [1:0]  exp_state;
        logic [65:0] got_out;
        logic [65:0] exp_out;
        i_stall       = stall_s;
        i_redirect    = redir_s;
        i_redirect_pc = redir_pc_s;
        i_imem_ack    = 1'b0;
        #1;
        req_seen     = o_imem_req;
        ack          = req_seen && (mem_cnt >= mem_delay);
        i_imem_ack   = ack;
        i_imem_rdata = ack ? mem_word(o_imem_addr) : $urandom;
        #1;
        exp_req = m_live && (m_stale || !(m_valid && stall_s));
        checks++;
        if (o_imem_req !== exp_req)
            $display("FAIL req: got %0b exp %0b at %0t", o_imem_req, exp_req, $time);
        if (o_imem_req !== exp_req) failures++;
        if (exp_req) begin
            exp_addr = m_stale ? m_stale_addr : m_fetch_pc;
            checks++;
            if (o_imem_addr !== exp_addr) begin
                failures++;
                $display("FAIL addr: got %h exp %h at %0t", o_imem_addr, exp_addr, $time);
            end
        end
        last_req = req_seen;
        @(posedge clk);
        if (req_seen) mem_cnt = ack ? 0 : mem_cnt + 1;
        if (!m_live) begin
            m_live = 1'b1;
        end else if (redir_s) begin
            m_valid = 1'b0;
            if (!m_stale) m_stale_addr = m_fetch_pc;
            m_stale    = exp_req && !ack;
            m_fetch_pc = redir_pc_s & 32'hFFFF_FFFC;
        end else if (exp_req && ack) begin
            if (m_stale) begin
                m_stale = 1'b0;
            end else begin
                m_instr    = mem_word(m_fetch_pc);
                m_rtype    = (m_instr >> 26) == 32'd0;
                m_pc       = m_fetch_pc;
                m_valid    = 1'b1;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end else if (m_valid && !stall_s) begin
            m_valid = 1'b0;
        end
        #1;
        got_out = {o_valid, o_R_type, o_pc, o_instruction};
        exp_out = {m_valid, m_rtype, m_pc, m_instr};
        checks++;
        if (got_out !== exp_out) begin
            failures++;
            $display("FAIL outreg: got v=%0b r=%0b pc=%h ins=%h exp v=%0b r=%0b pc=%h ins=%h at %0t",
                     o_valid, o_R_type, o_pc, o_instruction, m_valid, m_rtype, m_pc, m_instr, $time);
        end
        exp_state = !m_live ? 2'd0 : (m_stale ? 2'd2 : 2'd1);
        checks++;
        if (o_state_dbg !== exp_state) begin
            failures++;
            $display("FAIL state: got %0d exp %0d at %0t", o_state_dbg, exp_state, $time);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        stall_s    = 1'b0;
        redir_s    = 1'b0;
        i_stall    = 1'b0;
        i_redirect = 1'b0;
        i_imem_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({o_imem_req, o_valid, o_R_type, o_pc, o_instruction, o_state_dbg} !== 69'd0) begin
            failures++;
            $display("FAIL reset_vals: got req=%0b v=%0b r=%0b pc=%h ins=%h st=%0d exp all zero",
                     o_imem_req, o_valid, o_R_type, o_pc, o_instruction, o_state_dbg);
        end
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        mem_delay = 0;
        do_reset();
        step();
        #1;
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL first_req: got req=%0b addr=%h exp req=1 addr=%h", o_imem_req, o_imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        exp_q.push_back(32'h0000_A100);
        exp_q.push_back(32'h0000_A104);
        exp_q.push_back(32'h0000_A108);
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (o_instruction !== e || o_pc !== RESET_PC + 32'(4 * i) || o_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq%0d: got ins=%h pc=%h v=%0b exp ins=%h pc=%h v=1",
                         i, o_instruction, o_pc, o_valid, e, RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        mem_delay = 0;
        do_reset();
        step();
        step();
        step();
        stall_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_instruction !== 32'h0000_A104 || o_valid !== 1'b1 || last_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: got ins=%h v=%0b req=%0b exp ins=0000a104 v=1 req=0",
                         i, o_instruction, o_valid, last_req);
            end
        end
        stall_s = 1'b0;
        step();
        checks++;
        if (o_instruction !== 32'h0000_A108 || o_pc !== 32'h0000_0108 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got ins=%h pc=%h v=%0b exp ins=0000a108 pc=00000108 v=1",
                     o_instruction, o_pc, o_valid);
        end
    endtask

    task automatic test_redirect_flush();
        logic got;
        mem_delay = 0;
        do_reset();
        step();
        step();
        step();
        mem_delay = 3;
        step();
        redir_s    = 1'b1;
        redir_pc_s = 32'h0000_0203;
        step();
        redir_s = 1'b0;
        checks++;
        if (o_state_dbg !== 2'd2 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_enter: got st=%0d v=%0b exp st=2 v=0", o_state_dbg, o_valid);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = o_valid;
        end
        checks++;
        if (!got || o_pc !== 32'h0000_0200 || o_instruction !== 32'h0000_A200) begin
            failures++;
            $display("FAIL flush_refetch: got v=%0b pc=%h ins=%h exp v=1 pc=00000200 ins=0000a200",
                     got, o_pc, o_instruction);
        end
        mem_delay = 0;
    endtask

    task automatic test_opcode();
        mem_delay = 0;
        do_reset();
        step();
        ovr_en  = 1'b1;
        ovr_val = 32'h012A_4020;
        step();
        checks++;
        if (o_R_type !== 1'b1 || o_instruction !== 32'h012A_4020) begin
            failures++;
            $display("FAIL rtype_add: got r=%0b ins=%h exp r=1 ins=012a4020", o_R_type, o_instruction);
        end
        ovr_val = 32'h8D09_0004;
        step();
        checks++;
        if (o_R_type !== 1'b0 || o_instruction !== 32'h8D09_0004) begin
            failures++;
            $display("FAIL rtype_lw: got r=%0b ins=%h exp r=0 ins=8d090004", o_R_type, o_instruction);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_pc_wrap();
        mem_delay  = 0;
        redir_s    = 1'b1;
        redir_pc_s = 32'hFFFF_FFFC;
        step();
        redir_s = 1'b0;
        step();
        checks++;
        if (o_pc !== 32'hFFFF_FFFC || o_instruction !== 32'h0000_9FFC || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_last: got pc=%h ins=%h v=%0b exp pc=fffffffc ins=00009ffc v=1",
                     o_pc, o_instruction, o_valid);
        end
        step();
        checks++;
        if (o_pc !== 32'h0000_0000 || o_instruction !== 32'h0000_A000 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_zero: got pc=%h ins=%h v=%0b exp pc=00000000 ins=0000a000 v=1",
                     o_pc, o_instruction, o_valid);
        end
    endtask

    task automatic test_random();
        mem_delay = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall_s    = ($urandom_range(0, 99) < 30);
            redir_s    = ($urandom_range(0, 99) < 8);
            redir_pc_s = $urandom;
            if ($urandom_range(0, 9) == 0) mem_delay = $urandom_range(0, 3);
            step();
        end
        stall_s   = 1'b0;
        redir_s   = 1'b0;
        mem_delay = 0;
    endtask

    task automatic test_reset_mid_request();
        logic found;
        mem_delay = 3;
        stall_s   = 1'b0;
        redir_s   = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            found = o_valid && o_imem_req;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_req_setup: got no valid+req cycle exp one within 30 cycles");
        end
        i_imem_ack = 1'b0;
        rst_n      = 1'b0;
        #1;
        checks++;
        if (o_imem_req !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got req=%0b v=%0b exp req=0 v=0", o_imem_req, o_valid);
        end
        model_reset();
        mem_delay = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (o_pc !== RESET_PC || o_instruction !== 32'h0000_A100 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL restart: got pc=%h ins=%h v=%0b exp pc=%h ins=0000a100 v=1",
                     o_pc, o_instruction, o_valid, RESET_PC);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n         = 1'b0;
        i_imem_ack    = 1'b0;
        i_imem_rdata  = '0;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_flush();
        test_opcode();
        test_pc_wrap();
        test_random();
        test_reset_mid_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS pipeline. Maintains the program counter, issues word reads to instruction memory over a req/ack handshake, and presents one registered instruction per cycle, with the R-type flag, to the decode stage. Honours back-pressure (stall) from the hazard logic and redirects (branch/jump) from execute, discarding any fetch that is in flight.

## Interface
- `INST_LEN`, 32, instruction width.
- `PC_LEN`, 32, program-counter / memory-address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

- `i_sys_clk`  in  1  system clock; all state on rising edge.
- `i_sys_rst`  in  1  reset, asynchronous, active-low.
- `o_imem_req`  out  1  read request to instruction memory.
- `o_imem_addr`  out  PC_LEN  read address; word aligned, bits [1:0] always 0.
- `i_imem_ack`  in  1  read completes this cycle; `i_imem_rdata` is valid.
- `i_imem_rdata`  in  INST_LEN  instruction word.
- `i_stall`  in  1  decode cannot accept; hold the output register.
- `i_redirect`  in  1  branch/jump taken; flush and refetch.
- `i_redirect_pc`  in  PC_LEN  new fetch address; bits [1:0] ignored (forced 0).
- `o_valid`  out  1  `o_instruction` holds a live instruction.
- `o_instruction`  out  INST_LEN  fetched instruction.
- `o_R_type`  out  1  `o_instruction[31:26] == 6'b000000`, registered with the instruction.
- `o_pc`  out  PC_LEN  address of `o_instruction`.

## Operation
- Reset values:
  - PC = `RESET_PC`; state = IDLE.
  - `o_imem_req` = 0, `o_valid` = 0, `o_instruction` = 0, `o_R_type` = 0, `o_pc` = 0.
- States:
  - IDLE: occupied only on the first cycle after reset deasserts; goes to FETCH unconditionally.
  - FETCH: request at the current PC.
  - FLUSH: wait out a request made stale by a redirect.
- Request rule:
  - In FETCH, `o_imem_req` = !(`o_valid` && `i_stall`).
  - In FLUSH, `o_imem_req` = 1.
  - In IDLE, `o_imem_req` = 0.
- `o_imem_addr` = PC in FETCH; in FLUSH it is the stale address.
- Once `o_imem_req` is high, it and `o_imem_addr` stay stable until `i_imem_ack`. A stall arriving mid-request does not drop the request.
- Accept, in FETCH when `o_imem_req` && `i_imem_ack` && !`i_redirect`:
  - `o_instruction` ← rdata; `o_R_type` ← (rdata[31:26] == 0); `o_pc` ← PC; `o_valid` ← 1.
  - PC ← PC + 4, modulo 2^PC_LEN: 32'hFFFF_FFFC wraps to 0.
- Consume: when `o_valid` && !`i_stall` and there is no accept that cycle, `o_valid` ← 0.
- Stall: while `o_valid` && `i_stall`, the output register is frozen.
- Redirect (highest priority, any state except IDLE):
  - `o_valid` ← 0 and PC ← {`i_redirect_pc`[PC_LEN-1:2], 2'b00}. Any ack in the same cycle is discarded.
  - If a request is outstanding (req high, no ack this cycle), go to FLUSH. The stale request is held until its ack, the data is dropped, then go to FETCH at the new PC.
  - A second redirect while in FLUSH overwrites PC; the state stays FLUSH.
- Reset mid-request: the request drops immediately (asynchronous) and all registers return to their reset values.

## Timing
- First request is issued 1 cycle after reset deasserts, at address `RESET_PC`.
- Latency: ack in cycle N → `o_valid`/`o_instruction` visible in cycle N+1.
- With single-cycle ack and no stall, throughput is 1 instruction/cycle. The PC advances in the ack cycle, so the next address is requested at N+1.
- Redirect in cycle N with no outstanding request → the request at the new PC is issued at N+1.
- Redirect with an outstanding request → the new-PC request is issued the cycle after the stale ack.
- Stall asserted at N with `o_valid` = 1 → the output is unchanged at N+1. With no outstanding request, `o_imem_req` is 0 from N.

## Test plan
- Reset with `RESET_PC` = 0x100, memory returning addr+0xA000 with same-cycle ack:
  - `o_imem_req` goes high 1 cycle after reset release.
  - `o_instruction` sequence is 0xA100, 0xA104, 0xA108 on consecutive cycles, with `o_pc` = 0x100, 0x104, 0x108.
- Stall for 3 cycles while `o_valid` = 1 (instruction 0xA104):
  - The output holds 0xA104 for 3 cycles and no new request is issued.
  - On release, 0xA108 follows in the next cycle with no duplicate or gap.
- Redirect to 0x203 while memory has a 3-cycle ack delay and a request is outstanding at 0x108:
  - State enters FLUSH and `o_valid` = 0.
  - The stale 0x108 data is dropped; the next request is at 0x200 and delivers 0xA200.
- Opcode check:
  - rdata = 0x012A4020 (add) → `o_R_type` = 1.
  - rdata = 0x8D090004 (lw) → `o_R_type` = 0.
- PC wrap: redirect to 0xFFFFFFFC, two fetches → `o_pc` = 0xFFFFFFFC, then 0x00000000.
- Reset asserted while `o_imem_req` = 1 and no ack:
  - `o_imem_req` and `o_valid` drop asynchronously.
  - After release, fetching restarts at `RESET_PC`.
